// File: rtl/event_div_pkg.sv
// Shared encodings and limits for the multi-channel event divider.
package event_div_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_RSVD = 2'b11   // decoded as rising
  } edge_sel_e;

  typedef enum logic {
    MODE_GATE   = 1'b0,
    MODE_STROBE = 1'b1
  } mode_e;

  // Fewer than two flops gives no metastability protection on ev_in.
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/event_div_ch.sv
// One divider channel: synchroniser, edge detect, ratio shadow, event counter,
// gate-activity flag and registered output.
module event_div_ch
  import event_div_pkg::*;
#(
  parameter int CW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEFAULT_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [1:0]    edge_sel,
  input  logic          mode,
  input  logic [CW-1:0] div_ratio,
  input  logic          ev_in,
  output logic          ev_out,
  output logic [CW-1:0] ev_cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          shadow_q, shadow_d;
  logic                   act_q, act_d;
  logic                   term_q, term_d;
  logic                   out_q, out_d;
  logic [2:0]             cfg_q;
  logic                   cfg_chg;
  logic                   ev;
  logic                   lvl_s, lvl_sd;
  logic                   strobe_eff;
  logic [CW-1:0]          reff;
  logic                   terminal;

  assign s       = sync_q[SYNC_STAGES-1];
  assign cfg_chg = (cfg_q != {edge_sel, mode});

  // Synchroniser chain and edge history run regardless of en/clr, so
  // re-enabling never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      cfg_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ev_in};
      s_d_q  <= s;
      cfg_q  <= {edge_sel, mode};
    end
  end

  // Edge strobe, active level and effective output mode from edge_sel.
  always_comb begin
    ev         = s & ~s_d_q;
    lvl_s      = s;
    lvl_sd     = s_d_q;
    strobe_eff = (mode == MODE_STROBE);
    case (edge_sel)
      EDGE_FALL: begin
        ev     = ~s & s_d_q;
        lvl_s  = ~s;
        lvl_sd = ~s_d_q;
      end
      EDGE_BOTH: begin
        ev         = s ^ s_d_q;
        strobe_eff = 1'b1;    // no single active level, so gate degrades to strobe
      end
      default: ;
    endcase
  end

  // Shadow values 0 and 1 both divide by one.
  assign reff     = (shadow_q > CW'(1)) ? shadow_q : CW'(1);
  assign terminal = en & ~clr & ev & (cnt_q == reff - CW'(1));

  // Counter, shadow reload, gate flag and output next-state; clr beats events.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    act_d    = act_q;
    term_d   = 1'b0;
    out_d    = 1'b0;
    if (clr) begin
      cnt_d    = '0;
      shadow_d = div_ratio;
      act_d    = 1'b0;
    end else if (!en) begin
      act_d = 1'b0;
    end else begin
      if (ev) begin
        if (terminal) begin
          cnt_d    = '0;
          shadow_d = div_ratio;
          term_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // A new terminal keeps a running gate continuous.
      if (terminal && !strobe_eff) act_d = 1'b1;
      else if (cfg_chg || !lvl_s)  act_d = 1'b0;
      out_d = strobe_eff ? term_q : (act_q & lvl_sd);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= CW'(DEFAULT_DIV);
      act_q    <= 1'b0;
      term_q   <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      act_q    <= act_d;
      term_q   <= term_d;
      out_q    <= out_d;
    end
  end

  assign ev_out = out_q;
  assign ev_cnt = cnt_q;

endmodule

// File: rtl/event_divider_mc.sv
// Multi-channel programmable event divider: CH independent channels sharing
// global enable, clear, edge select and output mode.
module event_divider_mc
  import event_div_pkg::*;
#(
  parameter int CH          = 4,
  parameter int CW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       edge_sel,
  input  logic             mode,
  input  logic [CH*CW-1:0] div_ratio,
  input  logic [CH-1:0]    ev_in,
  output logic [CH-1:0]    ev_out,
  output logic [CH*CW-1:0] ev_cnt
);

  // Undersized synchroniser requests are raised to the safe minimum.
  localparam int SYNC_EFF = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    event_div_ch #(
      .CW          (CW),
      .SYNC_STAGES (SYNC_EFF),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
      .edge_sel  (edge_sel),
      .mode      (mode),
      .div_ratio (div_ratio[g*CW +: CW]),
      .ev_in     (ev_in[g]),
      .ev_out    (ev_out[g]),
      .ev_cnt    (ev_cnt[g*CW +: CW])
    );
  end

endmodule

// File: tb/tb_event_divider_mc.sv
// Scoreboard bench for event_divider_mc: stimulus pushes expected output
// pulses (channel, rise cycle, width); a negedge monitor measures each pulse
// and matches it against the queue.
module tb_event_divider_mc;
  import event_div_pkg::*;

  localparam int CH  = 4;
  localparam int CW  = 8;
  localparam int SS  = 2;
  localparam int LAT = SS + 2;

  logic             clk = 1'b0;
  logic             rst_n, en, clr, mode;
  logic [1:0]       edge_sel;
  logic [CH*CW-1:0] div_ratio;
  logic [CH-1:0]    ev_in, ev_out;
  logic [CH*CW-1:0] ev_cnt;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int ch;
    int rise;
    int width;
  } exp_t;
  exp_t sb[$];

  event_divider_mc #(.CH(CH), .CW(CW), .SYNC_STAGES(SS), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .edge_sel  (edge_sel),
    .mode      (mode),
    .div_ratio (div_ratio),
    .ev_in     (ev_in),
    .ev_out    (ev_out),
    .ev_cnt    (ev_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic chk_cnt(input int k, input int e);
    logic [CW-1:0] a;
    a = ev_cnt[k*CW +: CW];
    chk($sformatf("ev_cnt ch%0d", k), 64'(a), 64'(e));
  endtask

  task automatic check_pulse(input int k, input int r, input int w);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].ch == k) begin
        idx = i;
        break;
      end
    end
    n_vec++;
    if (idx < 0) begin
      n_err++;
      $display("FAIL pulse ch%0d: unexpected pulse rise %0d width %0d", k, r, w);
    end else begin
      if (sb[idx].rise != r || sb[idx].width != w) begin
        n_err++;
        $display("FAIL pulse ch%0d: got rise %0d width %0d expected rise %0d width %0d",
                 k, r, w, sb[idx].rise, sb[idx].width);
      end
      sb.delete(idx);
    end
  endtask

  // Monitor: time each ev_out pulse and retire it against the scoreboard.
  logic [CH-1:0] prev = '0;
  int            rise_at[CH];
  always @(negedge clk) begin
    for (int k = 0; k < CH; k++) begin
      if (ev_out[k] && !prev[k]) rise_at[k] = cyc;
      else if (!ev_out[k] && prev[k]) check_pulse(k, rise_at[k], cyc - rise_at[k]);
    end
    prev = ev_out;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int k, input int w);
    exp_t e;
    e.ch = k; e.rise = cyc + LAT; e.width = w;
    sb.push_back(e);
  endtask

  task automatic set_div(input int k, input int v);
    div_ratio[k*CW +: CW] = CW'(v);
  endtask

  task automatic do_clr();
    clr = 1'b1; step(1); clr = 1'b0; step(2);
  endtask

  // Invert ev_in[k] for w cycles, restore, idle gap cycles.
  task automatic pulse(input int k, input int w, input int gap, input bit exp_o, input int exp_w);
    if (exp_o) expect_pulse(k, exp_w);
    ev_in[k] = ~ev_in[k]; step(w);
    ev_in[k] = ~ev_in[k]; step(gap);
  endtask

  initial begin
    bit r4_out[8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    int r4_cnt[8] = '{1, 2, 3, 0, 1, 0, 1, 0};
    bit g_out[5]  = '{0, 0, 1, 0, 0};
    int g_cnt[5]  = '{1, 2, 0, 1, 2};

    rst_n = 1'b1; en = 1'b1; clr = 1'b0;
    edge_sel = EDGE_RISE; mode = MODE_STROBE;
    div_ratio = {CH{8'd2}}; ev_in = '0;
    #1 rst_n = 1'b0;

    // Reset: outputs stay quiet while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      step(1); ev_in = ~ev_in;
      chk("reset ev_out", 64'(ev_out), 64'd0);
    end
    chk("reset ev_cnt", 64'(ev_cnt), 64'd0);
    ev_in = '0; step(3);
    rst_n = 1'b1; step(2);

    // Default ratio 2, strobe, rising: pulses 2 and 4 emerge.
    for (int i = 1; i <= 4; i++) begin
      pulse(0, 3, 4, (i % 2 == 0), 1);
      chk_cnt(0, i % 2);
    end

    // Gate mode, R=3, 5-wide pulses: only pulse 3 passes, full width.
    set_div(0, 3); mode = MODE_GATE; do_clr();
    for (int i = 0; i < 5; i++) begin
      pulse(0, 5, 6, g_out[i], 5);
      chk_cnt(0, g_cnt[i]);
    end

    // Strobe, falling, R=0 on ch1 and R=1 on ch2: every edge passes.
    en = 1'b0; ev_in[2:1] = 2'b11; set_div(1, 0); set_div(2, 1); step(6);
    edge_sel = EDGE_FALL; mode = MODE_STROBE; en = 1'b1; do_clr();
    for (int i = 0; i < 4; i++) begin
      pulse(1 + (i % 2), 3, 4, 1'b1, 1);
      chk_cnt(1 + (i % 2), 0);
    end

    // Ratio 4 -> 2 after two events: terminal at 4, then every 2.
    edge_sel = EDGE_RISE; set_div(3, 4); do_clr();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) set_div(3, 2);
      pulse(3, 3, 4, r4_out[i], 1);
      chk_cnt(3, r4_cnt[i]);
    end

    // clr coincident with the third edge at R=3 drops that edge.
    set_div(0, 3); do_clr();
    pulse(0, 3, 4, 1'b0, 0); chk_cnt(0, 1);
    pulse(0, 3, 4, 1'b0, 0); chk_cnt(0, 2);
    ev_in[0] = 1'b1; step(2);
    clr = 1'b1; step(1); clr = 1'b0; step(1);
    ev_in[0] = 1'b0; step(5);
    chk_cnt(0, 0);
    for (int i = 1; i <= 3; i++) begin
      pulse(0, 3, 4, (i == 3), 1);
      chk_cnt(0, i % 3);
    end

    // Both edges, gate request (acts as strobe), ch0 R=2 and ch3 R=3.
    set_div(0, 2); set_div(3, 3); edge_sel = EDGE_BOTH; mode = MODE_GATE; do_clr();
    for (int i = 1; i <= 6; i++) begin
      if (i % 2 == 0) expect_pulse(0, 1);
      if (i % 3 == 0) expect_pulse(3, 1);
      ev_in ^= 4'b1001; step(5);
    end
    chk_cnt(0, 0); chk_cnt(3, 0);
    // en low across two edges: ignored, no spurious event on re-enable.
    en = 1'b0; step(1);
    ev_in ^= 4'b1001; step(4);
    ev_in ^= 4'b1001; step(5);
    chk_cnt(0, 0); chk_cnt(3, 0);
    en = 1'b1; step(5);
    chk("ev_out after re-enable", 64'(ev_out), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) expect_pulse(0, 1);
      if (i == 3) expect_pulse(3, 1);
      ev_in ^= 4'b1001; step(5);
    end
    chk_cnt(0, 1); chk_cnt(3, 0); chk_cnt(1, 0); chk_cnt(2, 0);

    step(20);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    chk("ev_out idle", 64'(ev_out), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/event_divider_mc.md
Name: event_divider_mc

Overview:
- Multi-channel, runtime-programmable event divider.
- Each channel synchronises an asynchronous event input and detects the selected edge. It passes every R-th event to its output, either as a gated copy of the input pulse or as a one-cycle strobe.
- Sits between raw external trigger/event pins and downstream counters or sequencers. Generalises the fixed divide-by-N divider with channel count, ratio width, edge select, output mode, enable, clear and count readback.

Parameters:
- CH, 4, number of independent channels.
- CW, 8, divide-ratio and event-counter width.
- SYNC_STAGES, 2, synchroniser flops per channel (minimum 2).
- DEFAULT_DIV, 2, divide ratio loaded at reset (must fit in CW bits).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low freezes counting.
- clr  in  1  synchronous restart, all channels.
- edge_sel  in  2  00 rising, 01 falling, 10 both, 11 reserved (treated as rising).
- mode  in  1  0 gate, 1 strobe.
- div_ratio  in  CH*CW  per-channel ratio R; channel k uses bits [k*CW +: CW].
- ev_in  in  CH  asynchronous event inputs.
- ev_out  out  CH  divided event outputs, registered.
- ev_cnt  out  CH*CW  per-channel current event count, registered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - synchroniser, edge-history, counter, act and ev_out flops go to 0;
  - ratio shadow goes to DEFAULT_DIV;
  - ev_out and ev_cnt are 0 while rst_n is low.
- Synchroniser: ev_in passes through SYNC_STAGES flops to give s. One further flop gives s_d. The event strobe is:
  - s & ~s_d for rising;
  - ~s & s_d for falling;
  - s ^ s_d for both.
- Effective ratio Reff = shadow, except shadow values 0 and 1 both mean divide-by-1.
- Shadow reload: shadow <= div_ratio slice on clr and on each terminal event. A mid-cycle ratio change therefore takes effect only at the next period boundary.
- Counter: on each event, if cnt == Reff-1 it is a terminal event and cnt <= 0; otherwise cnt <= cnt+1. ev_cnt mirrors cnt.
- Strobe mode: ev_out = 1 for exactly one cycle, in the cycle after the terminal event.
- Gate mode:
  - a terminal event sets act;
  - ev_out = act & active level of s, registered;
  - the active level is s=1 for rising and s=0 for falling;
  - act clears when s returns to the inactive level;
  - with edge_sel=10, gate mode behaves as strobe mode.
- Latency: ev_in transition to ev_out assertion is SYNC_STAGES+2 clk edges, in both modes.
- en low:
  - events ignored, cnt held;
  - act cleared, ev_out <= 0 next cycle;
  - synchroniser and edge history keep running, so no spurious edge fires on re-enable.
- clr:
  - cnt <= 0, act <= 0, ev_out <= 0, shadow reloaded;
  - edge history is kept;
  - clr wins over a coincident event (that event is dropped, not counted).
- Gate pulse still active when the next terminal event arrives: act stays set and the output remains continuous.
- Mode or edge_sel change mid-operation: takes effect next cycle; cnt is preserved; act is cleared.
- Input pulses shorter than one clk period may be missed; this is accepted.

Decomposition:
- Package event_div_pkg:
  - edge_sel encodings (EDGE_RISE, EDGE_FALL, EDGE_BOTH);
  - mode encodings (MODE_GATE, MODE_STROBE);
  - the minimum SYNC_STAGES constant.
- Sub-module event_div_ch: one channel (synchroniser, edge detect, shadow, counter, act, output).
- Top event_divider_mc: generate-instantiates CH copies and slices the div_ratio and ev_cnt buses.

Test Plan:
- Reset check: hold rst_n low while toggling ev_in -> ev_out=0, ev_cnt=0. Release, then 4 rising pulses at R=DEFAULT_DIV=2 -> ev_out strobes on pulses 2 and 4 only.
- Gate mode, ch0, R=3, rising, 5-cycle-wide input pulses -> pulse 3 appears on ev_out 5 cycles wide, delayed SYNC_STAGES+2 cycles; pulses 1, 2, 4, 5 are absent; ev_cnt sequence 1,2,0,1,2.
- Strobe mode, falling edge, R=0 and R=1 -> every falling edge yields a one-cycle ev_out; ev_cnt stays 0.
- Ratio change mid-period: R=4, after 2 events write R=2 -> terminal at event 4, then every 2 events thereafter.
- clr coincident with the 3rd edge at R=3 -> no output, ev_cnt=0; the next 3 edges produce one output.
- Both-edges mode, R=2, and en low for 10 cycles spanning 2 edges -> those edges are not counted, no output, no spurious event on re-enable; other channels with different R run independently.
